// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle Moore control sequencer for the MIPS datapath.
// Each instruction is stepped through fetch, decode, execute, memory and
// writeback. The memory states stall on mem_ready_in. In those states the
// IR/PC loads and the done pulse are gated by mem_ready_in, so each one fires
// exactly once per access.
// Optional feature macro: MIPS_MC_JALR_EN adds the jr and jal instructions
// (the JR and JAL states). Without it, both opcodes decode to ILLEGAL.
// Outputs are decoded from the current state with zero latency. They are
// forced to 0 while reset is high, so an aborted instruction never writes.
module mips_mc_control #(
  parameter bit FETCH_PC_INC = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_in,
  input  logic [5:0] func_in,
  input  logic       zero_in,
  input  logic       mem_ready_in,
  output logic       pcWrite_out,
  output logic       pcWriteCond_out,
  output logic       branchNe_out,
  output logic       iorD_out,
  output logic       memRead_out,
  output logic       memWrite_out,
  output logic       irWrite_out,
  output logic [1:0] regDst_out,
  output logic [1:0] memToReg_out,
  output logic       regWrite_out,
  output logic       ALUSrcA_out,
  output logic [1:0] ALUSrcB_out,
  output logic       extCntrl_out,
  output logic [3:0] ALUCntrl_out,
  output logic [1:0] PCSource_out,
  output logic       instrDone_out,
  output logic       illegal_out,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXE   = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_ITEXE   = 4'd9,
    S_ITWB    = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_JAL     = 4'd13,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_LUI = 4'b1111;

  state_t state_q, state_d;

  // The zero flag is combined with branchNe inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero_in;

  // Next-state selection from the current state, opcode/func and memory ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready_in) state_d = S_DECODE;
      S_DECODE: begin
        case (op_in)
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_LUI: state_d = S_ITEXE;
          OP_J:                    state_d = S_JUMP;
`ifdef MIPS_MC_JALR_EN
          OP_JAL:                  state_d = S_JAL;
`endif
          OP_RTYPE: begin
            case (func_in)
              FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR: state_d = S_RTEXE;
`ifdef MIPS_MC_JALR_EN
              FN_JR:   state_d = S_JR;
`endif
              default: state_d = S_ILLEGAL;
            endcase
          end
          default:                 state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op_in == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_in) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready_in) state_d = S_FETCH;
      S_RTEXE:  state_d = S_RTWB;
      S_ITEXE:  state_d = S_ITWB;
      S_MEMWB, S_RTWB, S_ITWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
`ifdef MIPS_MC_JALR_EN
      S_JR, S_JAL: state_d = S_FETCH;
`endif
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  // State register; synchronous reset returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Output decode: Moore per state, with mem_ready gating in the memory states.
  always_comb begin
    pcWrite_out     = 1'b0;
    pcWriteCond_out = 1'b0;
    branchNe_out    = 1'b0;
    iorD_out        = 1'b0;
    memRead_out     = 1'b0;
    memWrite_out    = 1'b0;
    irWrite_out     = 1'b0;
    regDst_out      = 2'b00;
    memToReg_out    = 2'b00;
    regWrite_out    = 1'b0;
    ALUSrcA_out     = 1'b0;
    ALUSrcB_out     = 2'b00;
    extCntrl_out    = 1'b0;
    ALUCntrl_out    = 4'b0000;
    PCSource_out    = 2'b00;
    instrDone_out   = 1'b0;
    illegal_out     = 1'b0;
    state_out       = 4'd0;
    if (!reset) begin
      state_out = state_q;
      case (state_q)
        S_FETCH: begin
          memRead_out  = 1'b1;
          ALUSrcB_out  = 2'b01;
          ALUCntrl_out = ALU_ADD;
          irWrite_out  = mem_ready_in;
          pcWrite_out  = mem_ready_in & FETCH_PC_INC;
        end
        S_DECODE: begin
          ALUSrcB_out  = 2'b11;
          extCntrl_out = 1'b1;
          ALUCntrl_out = ALU_ADD;
        end
        S_MEMADR: begin
          ALUSrcA_out  = 1'b1;
          ALUSrcB_out  = 2'b10;
          extCntrl_out = 1'b1;
          ALUCntrl_out = ALU_ADD;
        end
        S_MEMRD: begin
          memRead_out = 1'b1;
          iorD_out    = 1'b1;
        end
        S_MEMWB: begin
          regWrite_out  = 1'b1;
          memToReg_out  = 2'b01;
          instrDone_out = 1'b1;
        end
        S_MEMWR: begin
          memWrite_out  = 1'b1;
          iorD_out      = 1'b1;
          instrDone_out = mem_ready_in;
        end
        S_RTEXE: begin
          ALUSrcA_out = 1'b1;
          case (func_in)
            FN_ADD:  ALUCntrl_out = ALU_ADD;
            FN_SUB:  ALUCntrl_out = ALU_SUB;
            FN_AND:  ALUCntrl_out = ALU_AND;
            FN_OR:   ALUCntrl_out = ALU_OR;
            FN_SLT:  ALUCntrl_out = ALU_SLT;
            FN_NOR:  ALUCntrl_out = ALU_NOR;
            default: ALUCntrl_out = ALU_AND;
          endcase
        end
        S_RTWB: begin
          regWrite_out  = 1'b1;
          regDst_out    = 2'b01;
          instrDone_out = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA_out     = 1'b1;
          ALUCntrl_out    = ALU_SUB;
          pcWriteCond_out = 1'b1;
          PCSource_out    = 2'b01;
          branchNe_out    = (op_in == OP_BNE);
          instrDone_out   = 1'b1;
        end
        S_ITEXE: begin
          ALUSrcA_out = 1'b1;
          ALUSrcB_out = 2'b10;
          case (op_in)
            OP_ANDI: ALUCntrl_out = ALU_AND;
            // The extension choice is irrelevant for lui; zero-extend.
            OP_LUI:  ALUCntrl_out = ALU_LUI;
            default: begin
              extCntrl_out = 1'b1;
              ALUCntrl_out = ALU_ADD;
            end
          endcase
        end
        S_ITWB: begin
          regWrite_out  = 1'b1;
          instrDone_out = 1'b1;
        end
        S_JUMP: begin
          pcWrite_out   = 1'b1;
          PCSource_out  = 2'b10;
          instrDone_out = 1'b1;
        end
`ifdef MIPS_MC_JALR_EN
        S_JR: begin
          pcWrite_out   = 1'b1;
          PCSource_out  = 2'b11;
          instrDone_out = 1'b1;
        end
        // The jump and the link write happen in the same cycle; PC still holds PC+4.
        S_JAL: begin
          pcWrite_out   = 1'b1;
          PCSource_out  = 2'b10;
          regWrite_out  = 1'b1;
          regDst_out    = 2'b10;
          memToReg_out  = 2'b10;
          instrDone_out = 1'b1;
        end
`endif
        S_ILLEGAL: illegal_out = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed testbench for mips_mc_control. Inputs change 1 time unit after the
// rising edge, and outputs are sampled on the falling edge.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op_in, func_in;
  logic       zero_in, mem_ready_in;
  logic       pcWrite_out, pcWriteCond_out, branchNe_out, iorD_out;
  logic       memRead_out, memWrite_out, irWrite_out, regWrite_out;
  logic [1:0] regDst_out, memToReg_out, ALUSrcB_out, PCSource_out;
  logic       ALUSrcA_out, extCntrl_out, instrDone_out, illegal_out;
  logic [3:0] ALUCntrl_out, state_out;
  logic [27:0] all_out;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt;

  // Clock generation.
  always #5 clk = ~clk;

  mips_mc_control dut (
    .clk(clk), .reset(reset), .op_in(op_in), .func_in(func_in),
    .zero_in(zero_in), .mem_ready_in(mem_ready_in),
    .pcWrite_out(pcWrite_out), .pcWriteCond_out(pcWriteCond_out),
    .branchNe_out(branchNe_out), .iorD_out(iorD_out),
    .memRead_out(memRead_out), .memWrite_out(memWrite_out),
    .irWrite_out(irWrite_out), .regDst_out(regDst_out),
    .memToReg_out(memToReg_out), .regWrite_out(regWrite_out),
    .ALUSrcA_out(ALUSrcA_out), .ALUSrcB_out(ALUSrcB_out),
    .extCntrl_out(extCntrl_out), .ALUCntrl_out(ALUCntrl_out),
    .PCSource_out(PCSource_out), .instrDone_out(instrDone_out),
    .illegal_out(illegal_out), .state_out(state_out)
  );

  assign all_out = {pcWrite_out, pcWriteCond_out, branchNe_out, iorD_out,
                    memRead_out, memWrite_out, irWrite_out, regDst_out,
                    memToReg_out, regWrite_out, ALUSrcA_out, ALUSrcB_out,
                    extCntrl_out, ALUCntrl_out, PCSource_out, instrDone_out,
                    illegal_out, state_out};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Set mem_ready for this cycle and move to the sampling point.
  task automatic cyc(input logic rdy);
    mem_ready_in = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic rdy);
    check({tag, "_state"}, 32'(state_out), 32'd0);
    check({tag, "_memrd"}, 32'(memRead_out), 32'd1);
    check({tag, "_iord"}, 32'(iorD_out), 32'd0);
    check({tag, "_srcb"}, 32'(ALUSrcB_out), 32'd1);
    check({tag, "_alu"}, 32'(ALUCntrl_out), 32'd2);
    check({tag, "_irw"}, 32'(irWrite_out), 32'(rdy));
    check({tag, "_pcw"}, 32'(pcWrite_out), 32'(rdy));
  endtask

  task automatic check_decode(input string tag);
    check({tag, "_state"}, 32'(state_out), 32'd1);
    check({tag, "_srcb"}, 32'(ALUSrcB_out), 32'd3);
    check({tag, "_ext"}, 32'(extCntrl_out), 32'd1);
    check({tag, "_regw"}, 32'(regWrite_out), 32'd0);
  endtask

  logic [3:0] lw_st  [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
  logic       lw_rdy [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [5:0] rt_fn  [5] = '{6'h20, 6'h22, 6'h2a, 6'h27, 6'h25};
  logic [3:0] rt_alu [5] = '{4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0001};
  logic [5:0] it_op  [3] = '{6'h08, 6'h0c, 6'h0f};
  logic       it_ext [3] = '{1'b1, 1'b0, 1'b0};
  logic [3:0] it_alu [3] = '{4'b0010, 4'b0000, 4'b1111};

  initial begin
    reset = 1'b1; op_in = 6'h00; func_in = 6'h00; zero_in = 1'b0; mem_ready_in = 1'b1;

    // Reset held for 3 cycles: every output is 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_all", 32'(all_out), 32'd0);
    end
    adv();
    reset = 1'b0;
    op_in = 6'h23;

    // lw with two stall cycles in MEMRD: states 0,1,2,3,3,3,4.
    done_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(lw_rdy[i]);
      if (i == 0) check_fetch("rst_fetch", 1'b1);
      check("lw_state", 32'(state_out), 32'(lw_st[i]));
      check("lw_regw", 32'(regWrite_out), 32'(lw_st[i] == 4'd4));
      check("lw_m2r", 32'(memToReg_out), (lw_st[i] == 4'd4) ? 32'd1 : 32'd0);
      if (lw_st[i] == 4'd3) begin
        check("lw_memrd", 32'(memRead_out), 32'd1);
        check("lw_iord", 32'(iorD_out), 32'd1);
        check("lw_irw", 32'(irWrite_out), 32'd0);
      end
      if (lw_st[i] == 4'd2) check("lw_srcb", 32'(ALUSrcB_out), 32'd2);
      done_cnt += int'(instrDone_out);
      adv();
    end
    check("lw_done_cnt", 32'(done_cnt), 32'd1);

    // sw with a stall cycle in FETCH and another in MEMWR.
    op_in = 6'h2b;
    cyc(1'b0); check_fetch("sw_fstall", 1'b0); adv();
    cyc(1'b1); check_fetch("sw_fetch", 1'b1); adv();
    cyc(1'b1); check_decode("sw_dec"); adv();
    cyc(1'b1); check("sw_adr", 32'(state_out), 32'd2); adv();
    cyc(1'b0);
    check("sw_wr_state", 32'(state_out), 32'd5);
    check("sw_memw", 32'(memWrite_out), 32'd1);
    check("sw_done_wait", 32'(instrDone_out), 32'd0);
    adv();
    cyc(1'b1);
    check("sw_wr_state2", 32'(state_out), 32'd5);
    check("sw_memrd", 32'(memRead_out), 32'd0);
    check("sw_done", 32'(instrDone_out), 32'd1);
    adv();

    // R-type ALU codes.
    for (int i = 0; i < 5; i++) begin
      op_in = 6'h00; func_in = rt_fn[i];
      cyc(1'b1); check_fetch("rt_fetch", 1'b1); adv();
      cyc(1'b1); check_decode("rt_dec"); adv();
      cyc(1'b1);
      check("rt_exe_state", 32'(state_out), 32'd6);
      check("rt_alu", 32'(ALUCntrl_out), 32'(rt_alu[i]));
      check("rt_srca", 32'(ALUSrcA_out), 32'd1);
      adv();
      cyc(1'b1);
      check("rt_wb_state", 32'(state_out), 32'd7);
      check("rt_regdst", 32'(regDst_out), 32'd1);
      check("rt_regw", 32'(regWrite_out), 32'd1);
      check("rt_done", 32'(instrDone_out), 32'd1);
      adv();
    end

    // bne then beq, 3 cycles each; the following FETCH check confirms the count.
    for (int i = 0; i < 2; i++) begin
      op_in = (i == 0) ? 6'h05 : 6'h04;
      cyc(1'b1); check_fetch("br_fetch", 1'b1); adv();
      cyc(1'b1); check_decode("br_dec"); adv();
      cyc(1'b1);
      check("br_state", 32'(state_out), 32'd8);
      check("br_pcwc", 32'(pcWriteCond_out), 32'd1);
      check("br_ne", 32'(branchNe_out), (i == 0) ? 32'd1 : 32'd0);
      check("br_pcsrc", 32'(PCSource_out), 32'd1);
      check("br_alu", 32'(ALUCntrl_out), 32'd6);
      adv();
    end

    // addi / andi / lui.
    for (int i = 0; i < 3; i++) begin
      op_in = it_op[i];
      cyc(1'b1); check_fetch("it_fetch", 1'b1); adv();
      cyc(1'b1); check_decode("it_dec"); adv();
      cyc(1'b1);
      check("it_state", 32'(state_out), 32'd9);
      check("it_ext", 32'(extCntrl_out), 32'(it_ext[i]));
      check("it_alu", 32'(ALUCntrl_out), 32'(it_alu[i]));
      check("it_srcb", 32'(ALUSrcB_out), 32'd2);
      adv();
      cyc(1'b1);
      check("it_wb_state", 32'(state_out), 32'd10);
      check("it_wb_regw", 32'(regWrite_out), 32'd1);
      check("it_wb_regdst", 32'(regDst_out), 32'd0);
      adv();
    end

    // j.
    op_in = 6'h02;
    cyc(1'b1); check_fetch("j_fetch", 1'b1); adv();
    cyc(1'b1); check_decode("j_dec"); adv();
    cyc(1'b1);
    check("j_state", 32'(state_out), 32'd11);
    check("j_pcw", 32'(pcWrite_out), 32'd1);
    check("j_pcsrc", 32'(PCSource_out), 32'd2);
    adv();

    // Reset while in RTWB: no write enable in that cycle.
    op_in = 6'h00; func_in = 6'h20;
    cyc(1'b1); adv();
    cyc(1'b1); adv();
    cyc(1'b1); adv();
    reset = 1'b1;
    cyc(1'b1); check("midrst_all", 32'(all_out), 32'd0); adv();
    reset = 1'b0;
    op_in = 6'h3f;
    cyc(1'b1); check_fetch("midrst_fetch", 1'b1); adv();

    // Illegal opcode: sticky until reset.
    cyc(1'b1); check_decode("ill_dec"); adv();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      check("ill_state", 32'(state_out), 32'd15);
      check("ill_flag", 32'(illegal_out), 32'd1);
      check("ill_wr", 32'({pcWrite_out, pcWriteCond_out, regWrite_out, memWrite_out, irWrite_out}), 32'd0);
      adv();
    end
    reset = 1'b1;
    cyc(1'b1); check("ill_rst_all", 32'(all_out), 32'd0); adv();
    reset = 1'b0;
    op_in = 6'h03;
    cyc(1'b1); check_fetch("ill_rst_fetch", 1'b1); adv();

    // jal: the JAL state when built, otherwise ILLEGAL.
    cyc(1'b1); check_decode("jal_dec"); adv();
    cyc(1'b1);
`ifdef MIPS_MC_JALR_EN
    check("jal_state", 32'(state_out), 32'd13);
    check("jal_pcw", 32'(pcWrite_out), 32'd1);
    check("jal_pcsrc", 32'(PCSource_out), 32'd2);
    check("jal_regw", 32'(regWrite_out), 32'd1);
    check("jal_regdst", 32'(regDst_out), 32'd2);
    check("jal_m2r", 32'(memToReg_out), 32'd2);
    adv();
    op_in = 6'h00; func_in = 6'h08;
    cyc(1'b1); check_fetch("jr_fetch", 1'b1); adv();
    cyc(1'b1); adv();
    cyc(1'b1);
    check("jr_state", 32'(state_out), 32'd12);
    check("jr_pcsrc", 32'(PCSource_out), 32'd3);
`else
    check("jal_state", 32'(state_out), 32'd15);
    check("jal_illegal", 32'(illegal_out), 32'd1);
    check("jal_regw", 32'(regWrite_out), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared-memory, IR, PC, register-file and ALU enables of the multi-cycle datapath, and stalls on a memory-ready handshake. ALU operation codes are the ones the datapath ALU already implements: add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100, lui 1111.

## Interface
- `FETCH_PC_INC`, default 1: 1 means PC+4 is written in FETCH. 0 is reserved for test only and suppresses the PC update.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_in`  in  6  IR[31:26].
- `func_in`  in  6  IR[5:0].
- `zero_in`  in  1  ALU zero flag.
- `mem_ready_in`  in  1  memory completes the current access this cycle.
- `pcWrite_out`  out  1  unconditional PC load.
- `pcWriteCond_out`  out  1  conditional PC load. The datapath loads PC when (zero XOR branchNe).
- `branchNe_out`  out  1  1 selects bne.
- `iorD_out`  out  1  memory address select: 0 PC, 1 ALUOut.
- `memRead_out` / `memWrite_out`  out  1 each  memory strobes.
- `irWrite_out`  out  1  IR load.
- `regDst_out`  out  2  write register select: 00 rt, 01 rd, 10 $31.
- `memToReg_out`  out  2  write data select: 00 ALUOut, 01 MDR, 10 PC.
- `regWrite_out`  out  1  register file write enable.
- `ALUSrcA_out`  out  1  ALU input A: 0 PC, 1 regA.
- `ALUSrcB_out`  out  2  ALU input B: 00 regB, 01 const 4, 10 ext imm, 11 ext imm<<2.
- `extCntrl_out`  out  1  1 sign-extend, 0 zero-extend.
- `ALUCntrl_out`  out  4  ALU operation.
- `PCSource_out`  out  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target, 11 regA.
- `instrDone_out`  out  1  one-cycle pulse in the last state of each instruction.
- `illegal_out`  out  1  sticky illegal-opcode flag.
- `state_out`  out  4  current state, for debug.

## Operation
- **State encoding.** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, RTWB=7, BRANCH=8, ITEXE=9, ITWB=10, JUMP=11, JR=12, JAL=13, ILLEGAL=15.
- **FETCH.** Asserts memRead=1, iorD=0, ALUSrcA=0, ALUSrcB=01, ALU=0010, PCSource=00.
  - irWrite and pcWrite are asserted only when mem_ready_in=1 (Mealy gating).
  - The state holds until mem_ready_in=1, then moves to DECODE.
- **DECODE.** Computes the branch target: ALUSrcA=0, ALUSrcB=11, ext=1, ALU=0010. Next state by opcode:
  - lw (0x23) and sw (0x2b) → MEMADR.
  - op 0 with func add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a or nor 0x27 → RTEXE.
  - beq (0x4) and bne (0x5) → BRANCH.
  - addi (0x8), andi (0xc) and lui (0xf) → ITEXE.
  - j (0x2) → JUMP.
  - Anything else → ILLEGAL.
- **MEMADR.** ALUSrcA=1, ALUSrcB=10, ext=1, ALU=0010. Goes to MEMRD for lw, MEMWR for sw.
- **MEMRD.** memRead=1, iorD=1. Holds until mem_ready_in=1, then moves to MEMWB.
- **MEMWB.** regWrite=1, regDst=00, memToReg=01. Then FETCH.
- **MEMWR.** memWrite=1, iorD=1. Holds until mem_ready_in=1, then moves to FETCH.
- **RTEXE.** ALUSrcA=1, ALUSrcB=00, ALU selected by func. Then RTWB.
- **RTWB.** regWrite=1, regDst=01, memToReg=00. Then FETCH.
- **BRANCH.** ALUSrcA=1, ALUSrcB=00, ALU=0110, pcWriteCond=1, PCSource=01. branchNe=1 for bne. Then FETCH.
- **ITEXE.** ALUSrcA=1, ALUSrcB=10, then by opcode:
  - addi: ext=1, ALU=0010.
  - andi: ext=0, ALU=0000.
  - lui: ext=x, ALU=1111.
  - Then ITWB.
- **ITWB.** regWrite=1, regDst=00, memToReg=00. Then FETCH.
- **JUMP.** pcWrite=1, PCSource=10. Then FETCH.
- **ILLEGAL.** illegal_out=1 and all write enables 0. Exits only on reset.
- **Done pulse.** instrDone_out=1 in MEMWB, MEMWR (when ready), RTWB, BRANCH, ITWB, JUMP, JR and JAL.
- **Default outputs.** Every output not listed for a state is 0.

## Timing
- **Reset.** While reset=1:
  - The state register loads FETCH.
  - All outputs are 0, including memRead and state_out, and illegal_out clears.
  - The first fetch strobe appears in the first cycle after reset deasserts.
- **Output timing.** Outputs are a function of the current state, plus mem_ready_in gating in the memory states. They have zero latency and no internal delay.
- **Cycle counts with mem_ready_in tied high.**
  - lw: 5 cycles.
  - sw, R-type, addi/andi/lui: 4 cycles.
  - beq/bne, j, jr, jal: 3 cycles.
  - Each wait cycle adds one cycle.
- **Memory stall.** While mem_ready_in=0, the outputs of the memory state are held stable. No enable pulses twice.
- **Reset during an instruction.** Reset asserted in any state aborts the instruction. No write enable is asserted in that cycle.

## Configuration
- **`MIPS_MC_JALR_EN` defined:**
  - op 0 with func 0x08 (jr) → JR: pcWrite=1, PCSource=11.
  - op 0x3 (jal) → JAL, in a single cycle:
    - pcWrite=1, PCSource=10.
    - regWrite=1, regDst=10, memToReg=10, so PC+4 is written to $31.
  - Both then return to FETCH.
- **Not defined:** jr and jal decode to ILLEGAL, and the JR and JAL states are not built.

## Test plan
- **Reset.** Hold reset 3 cycles → all outputs 0. Release → state 0 with memRead=1; with mem_ready=1, irWrite=1 and pcWrite=1.
- **lw stall.** op=0x23 with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0. regWrite=1, memToReg=01 only in state 4. instrDone pulses once.
- **R-type ALU codes.** add, sub, slt, nor, or → RTEXE ALUCntrl 0010, 0110, 0111, 1100, 0001 respectively. RTWB regDst=01.
- **bne.** op=0x5 → BRANCH with pcWriteCond=1, branchNe=1, PCSource=01, ALU=0110. 3 cycles total.
- **Illegal and reset.** op=0x3F → state 15 with illegal_out=1 held for 10 cycles. Reset → FETCH.
- **JAL macro.** jal with macro defined → JAL state with regDst=10, memToReg=10, regWrite=1. Without the macro → ILLEGAL.
